operand_fetch_stage: RTL
========================

// Module: operand_fetch_stage
// PURPOSE
//  Issue stage between decode and execute. Drives the register bank read addresses, captures operands,
//  bypasses same-cycle writebacks and tracks pending writes in a 32-entry scoreboard.
//  Stalls decode on RAW/WAW hazards and hands execute one registered operand packet per accepted instruction.
// PARAMETERS
//  DATA_W    64  operand / writeback data width
//  ADDR_W    5   register address width (32 registers)
//  ZERO_REG  31  register index that always reads 0, is never written and is never busy
// PORTS
//  Clk       in   1       rising-edge clock
//  Reset     in   1       asynchronous, active-high reset
//  InValid   in   1       decode presents an instruction
//  InReady   out  1       stage accepts the instruction this cycle (combinational)
//  InAddrA   in   ADDR_W  source register A
//  InAddrB   in   ADDR_W  source register B
//  InAddrC   in   ADDR_W  destination register
//  InWrite   in   1       instruction writes InAddrC
//  RegAddrA  out  ADDR_W  register bank read address A (= InAddrA, combinational)
//  RegAddrB  out  ADDR_W  register bank read address B (= InAddrB, combinational)
//  RegDataA  in   DATA_W  register bank read data A (combinational from bank)
//  RegDataB  in   DATA_W  register bank read data B
//  WbValid   in   1       writeback this cycle (same strobe as the bank's w)
//  WbAddr    in   ADDR_W  writeback register
//  WbData    in   DATA_W  writeback data
//  OutValid  out  1       operand packet valid to execute
//  OutReady  in   1       execute accepts the packet
//  OutOpA    out  DATA_W  operand A
//  OutOpB    out  DATA_W  operand B
//  OutAddrC  out  ADDR_W  destination register
//  OutWrite  out  1       destination write flag
// BEHAVIOUR
//  Reset: OutValid=0, OutOpA=OutOpB=0, OutAddrC=0, OutWrite=0; all scoreboard bits cleared. Reset asserted
//   mid-operation discards the held packet and every pending entry, with no further handshake.
//  Scoreboard busy[0:31]. busy[ZERO_REG] is hard-wired to 0.
//  Source hazard hzA: InAddrA!=ZERO_REG && busy[InAddrA] && !(WbValid && WbAddr==InAddrA). hzB is defined the same way.
//  Dest hazard hzC: InWrite && InAddrC!=ZERO_REG && busy[InAddrC] && !(WbValid && WbAddr==InAddrC).
//  Slot free: free = !OutValid || OutReady. InReady = free && !hzA && !hzB && !hzC.
//  Accept = InValid && InReady. Latency: 1 cycle. The packet is registered on the accepting edge.
//  Operand select per source (priority order):
//   1) address == ZERO_REG: 0
//   2) WbValid && WbAddr == address: WbData (bypass)
//   3) otherwise: RegDataA / RegDataB
//  On accept: OutValid<=1, the operands are latched, OutAddrC<=InAddrC, OutWrite<=InWrite && InAddrC!=ZERO_REG.
//  If OutReady is high and nothing is accepted, OutValid<=0. A held packet (OutValid && !OutReady) is stable:
//   every Out* output holds its value.
//  Scoreboard update per edge:
//   - WbValid && WbAddr != ZERO_REG: clear busy[WbAddr].
//   - Accept && OutWrite-condition: set busy[InAddrC]. Set wins over clear when both target the same register.
//  Writebacks to ZERO_REG are ignored for both bypass and scoreboard.
//  Writeback to a non-busy register (e.g. an initial value load) is legal: the bit stays 0 and bypass still applies.
//  Same-register sources (InAddrA==InAddrB) obey the same rules independently.
//  An instruction whose source is also its own destination (e.g. A=C=5) checks hzA before the set,
//   so it reads the old value.
// TESTING
//  1. Reset high, then low, with the bank holding r[j]=j. Issue A=3, B=4, C=5, W=1 -> next cycle OutOpA=3,
//     OutOpB=4, OutAddrC=5, busy[5]=1.
//  2. Then issue A=5 with no writeback -> InReady=0 (stall). Assert WbValid, WbAddr=5, WbData=0x99 ->
//     InReady=1 the same cycle, OutOpA=0x99 next cycle, busy[5] cleared.
//  3. Issue A=31, B=31, C=31, W=1 with WbValid on r31=0xFF -> OutOpA=OutOpB=0, OutWrite=0, no busy bit set,
//     no stall.
//  4. Hold OutReady=0 for 3 cycles with InValid=1 -> InReady=0 and Out* stable. Raise OutReady ->
//     the new packet appears on the next edge with no bubble.
//  5. WAW: busy[7]=1, issue C=7, W=1 -> stall. Writeback r7 in the same cycle -> accept, busy[7] stays 1.
//  6. Assert Reset while OutValid=1 and busy[2]=1 -> OutValid=0 and busy all 0 immediately,
//     without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch / issue stage: reads the register bank, bypasses same-cycle writebacks,
// tracks pending writes in a scoreboard and hands execute one registered operand packet.
module operand_fetch_stage #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [ADDR_W-1:0] InAddrA,
  input  logic [ADDR_W-1:0] InAddrB,
  input  logic [ADDR_W-1:0] InAddrC,
  input  logic              InWrite,
  output logic [ADDR_W-1:0] RegAddrA,
  output logic [ADDR_W-1:0] RegAddrB,
  input  logic [DATA_W-1:0] RegDataA,
  input  logic [DATA_W-1:0] RegDataB,
  input  logic              WbValid,
  input  logic [ADDR_W-1:0] WbAddr,
  input  logic [DATA_W-1:0] WbData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutOpA,
  output logic [DATA_W-1:0] OutOpB,
  output logic [ADDR_W-1:0] OutAddrC,
  output logic              OutWrite
);

  localparam int unsigned NumRegs = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [NumRegs-1:0] busy;
  logic [NumRegs-1:0] busyNext;
  logic               wbLive;
  logic               hitA;
  logic               hitB;
  logic               hitC;
  logic               hzA;
  logic               hzB;
  logic               hzC;
  logic               slotFree;
  logic               accept;
  logic               destWrite;
  logic [DATA_W-1:0]  opA;
  logic [DATA_W-1:0]  opB;

  assign RegAddrA = InAddrA;
  assign RegAddrB = InAddrB;

  // Hazard detection; a writeback landing this cycle resolves the hazard it targets.
  always_comb begin
    wbLive    = WbValid && (WbAddr != ZeroAddr);
    hitA      = wbLive && (WbAddr == InAddrA);
    hitB      = wbLive && (WbAddr == InAddrB);
    hitC      = wbLive && (WbAddr == InAddrC);
    destWrite = InWrite && (InAddrC != ZeroAddr);
    hzA       = (InAddrA != ZeroAddr) && busy[InAddrA] && !hitA;
    hzB       = (InAddrB != ZeroAddr) && busy[InAddrB] && !hitB;
    hzC       = destWrite && busy[InAddrC] && !hitC;
    slotFree  = !OutValid || OutReady;
    InReady   = slotFree && !hzA && !hzB && !hzC;
    accept    = InValid && InReady;
  end

  // Operand select: zero register, then bypass, then bank data.
  always_comb begin
    opA = RegDataA;
    opB = RegDataB;
    if (InAddrA == ZeroAddr) opA = '0;
    else if (hitA)           opA = WbData;
    if (InAddrB == ZeroAddr) opB = '0;
    else if (hitB)           opB = WbData;
  end

  // Scoreboard next state: set after clear so an issuing writer wins over a retiring one.
  always_comb begin
    busyNext = busy;
    if (wbLive)
      busyNext[WbAddr] = 1'b0;
    if (accept && destWrite)
      busyNext[InAddrC] = 1'b1;
    busyNext[ZeroAddr] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  // Output packet register; holds while execute back-pressures.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OutValid <= 1'b0;
      OutOpA   <= '0;
      OutOpB   <= '0;
      OutAddrC <= '0;
      OutWrite <= 1'b0;
    end else if (accept) begin
      OutValid <= 1'b1;
      OutOpA   <= opA;
      OutOpB   <= opB;
      OutAddrC <= InAddrC;
      OutWrite <= destWrite;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule
